reg_file_wb_decode: RTL and testbench
=====================================

// Module: reg_file_wb_decode
// PURPOSE
//  Write-back end of the 5-bit destination-register select path. Takes the
//  selected destination address (rd/rt/$31 choice) and the write-back data,
//  decodes it one-hot, and commits it to a 32x32 register file.
//  Also provides two synchronous read ports with write-to-read bypass, and a
//  pending-write scoreboard. Decode uses the scoreboard to stall on RAW hazards.
// PARAMETERS
//  DATA_W    32  register data width
//  ADDR_W    5   register address width (NUM_REGS = 2**ADDR_W)
// PORTS
//  clk        in   1       single clock, rising edge
//  rst        in   1       asynchronous, active-high reset
//  iss_valid  in   1       decode issues an instr that will write iss_rd
//  iss_rd     in   ADDR_W  destination reg being reserved
//  wb_en      in   1       write-back strobe
//  wb_addr    in   ADDR_W  selected destination address (from dest mux)
//  wb_data    in   DATA_W  write-back data
//  rd_en      in   1       read request (both ports)
//  ra_addr    in   ADDR_W  read port A address
//  rb_addr    in   ADDR_W  read port B address
//  ra_data    out  DATA_W  port A data, registered
//  rb_data    out  DATA_W  port B data, registered
//  rd_valid   out  1       ra/rb_data valid this cycle
//  hazard     out  1       ra_addr or rb_addr has a pending write (comb.)
// BEHAVIOUR
//  - Reset (async): all 32 regs = 0, scoreboard = 0, ra/rb_data = 0, rd_valid = 0.
//  - Reg 0 is hardwired zero: writes to addr 0 are dropped. Issues to addr 0
//    never set a scoreboard bit. Reads of addr 0 always return 0.
//  - Write: when wb_en=1, regs[wb_addr] <= wb_data at the edge.
//    The one-hot write-enable vector is dec(wb_addr) & {32{wb_en}}.
//  - Read: latency 1. When rd_en=1 at edge N, ra/rb_data are valid after N and
//    rd_valid=1 for exactly that one cycle. When rd_en=0, ra/rb_data hold their
//    value and rd_valid=0.
//  - Bypass: if wb_en=1 and wb_addr==ra_addr!=0 in the same cycle as rd_en,
//    ra_data = wb_data (new value). Port B behaves the same way.
//  - Scoreboard, sb[31:0]:
//      set   sb[iss_rd] when iss_valid=1 and iss_rd!=0
//      clear sb[wb_addr] when wb_en=1
//      If set and clear hit the same address in one cycle, set wins: the new
//      instr's reservation survives the older write-back.
//  - hazard = (sb[ra_addr] & ~bypass_a) | (sb[rb_addr] & ~bypass_b).
//    bypass_x is true when the write-back completing this cycle matches port x.
//    Address 0 never hazards.
//  - wb_en to an address with sb=0 is legal: write proceeds, sb stays 0.
//  - Reset mid-operation clears all state immediately. Outputs read 0 from the
//    reset assertion, independent of clk.
// STRUCTURE
//  - Shared package rf_pkg: NUM_REGS=32, REG_ZERO=5'd0, REG_LINK=5'd31,
//    typedef reg_addr_t [4:0], typedef reg_data_t [31:0].
//  - One sub-module, dec5_32: combinational 5-to-32 one-hot decoder with an
//    enable input. It is instantiated for the write strobe, the scoreboard set
//    and the scoreboard clear.
//  - Top level holds the register array, the scoreboard flops, the read
//    registers and the bypass compare logic.
// TESTING
//  1. Reset: assert rst mid-clock with non-zero regs.
//     -> ra/rb_data=0, rd_valid=0, hazard=0 immediately; all reads return 0
//     after release.
//  2. Write/read: wb_en, addr 5, data 0xDEADBEEF; next cycle rd_en with
//     ra_addr=5 -> ra_data=0xDEADBEEF one cycle later, rd_valid=1 for 1 cycle.
//  3. Zero reg: wb_en, addr 0, data 0xFFFFFFFF, then read addr 0 -> 0.
//     iss_valid with iss_rd=0 -> hazard stays 0.
//  4. Bypass: same cycle wb_en addr 31 data 0x1234 and rd_en ra=31, rb=31
//     -> ra_data=rb_data=0x1234 next cycle; hazard=0 in that cycle.
//  5. Scoreboard: issue rd=7; next cycle ra_addr=7 -> hazard=1.
//     wb_en addr 7 -> hazard=0 that cycle; sb[7]=0 after.
//  6. Set/clear collision: iss_valid rd=9 and wb_en addr 9 in the same cycle
//     -> sb[9]=1 after the edge; hazard on ra=9 the following cycle.

Source files
------------

// File: rtl/rf_pkg.sv
// Shared register-file definitions for the write-back / decode slice.
package rf_pkg;
  localparam int unsigned NUM_REGS = 32;
  localparam logic [4:0]  REG_ZERO = 5'd0;
  localparam logic [4:0]  REG_LINK = 5'd31;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [31:0] reg_data_t;
endpackage

// File: rtl/reg_file_wb_decode_dec5_32.sv
// Combinational 5-to-32 one-hot decoder; all-zero output when en is low.
module dec5_32 #(
  parameter int unsigned ADDR_W = 5
) (
  input  logic                   en,
  input  logic [ADDR_W-1:0]      addr,
  output logic [2**ADDR_W-1:0]   onehot
);

  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/reg_file_wb_decode.sv
// Write-back register file: one-hot write decode, two bypassed synchronous
// read ports and a pending-write scoreboard driving the RAW hazard flag.
module reg_file_wb_decode
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  output logic              rd_valid,
  output logic              hazard
);

  localparam int unsigned      NREGS     = 2**ADDR_W;
  localparam logic [NREGS-1:0] ZERO_MASK = NREGS'(1);
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic [DATA_W-1:0] regs [NREGS];
  logic [NREGS-1:0]  sb;
  logic [NREGS-1:0]  we_raw, we;
  logic [NREGS-1:0]  set_raw, sb_set, sb_clr;
  logic              bypass_a, bypass_b;
  logic [DATA_W-1:0] ra_next, rb_next;

  dec5_32 #(.ADDR_W(ADDR_W)) u_dec_we (
    .en     (wb_en),
    .addr   (wb_addr),
    .onehot (we_raw)
  );

  dec5_32 #(.ADDR_W(ADDR_W)) u_dec_set (
    .en     (iss_valid),
    .addr   (iss_rd),
    .onehot (set_raw)
  );

  dec5_32 #(.ADDR_W(ADDR_W)) u_dec_clr (
    .en     (wb_en),
    .addr   (wb_addr),
    .onehot (sb_clr)
  );

  // Register 0 is hardwired: never written, never reserved.
  assign we     = we_raw  & ~ZERO_MASK;
  assign sb_set = set_raw & ~ZERO_MASK;

  assign bypass_a = wb_en && (wb_addr == ra_addr) && (ra_addr != ZERO_ADDR);
  assign bypass_b = wb_en && (wb_addr == rb_addr) && (rb_addr != ZERO_ADDR);

  // A write-back landing this cycle resolves the hazard it would have raised.
  assign hazard = (sb[ra_addr] & ~bypass_a) | (sb[rb_addr] & ~bypass_b);

  always_comb begin
    ra_next = regs[ra_addr];
    rb_next = regs[rb_addr];
    if (bypass_a) ra_next = wb_data;
    if (bypass_b) rb_next = wb_data;
    if (ra_addr == ZERO_ADDR) ra_next = '0;
    if (rb_addr == ZERO_ADDR) rb_next = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NREGS); i++) regs[i] <= '0;
    end else begin
      for (int i = 0; i < int'(NREGS); i++) begin
        if (we[i]) regs[i] <= wb_data;
      end
    end
  end

  // Set after clear so a new reservation outlives an older write-back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) sb <= '0;
    else     sb <= (sb & ~sb_clr) | sb_set;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ra_data  <= '0;
      rb_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_en;
      if (rd_en) begin
        ra_data <= ra_next;
        rb_data <= rb_next;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_wb_decode.sv
// Self-checking bench for reg_file_wb_decode: directed scenarios plus
// randomized traffic against a behavioural register-file model.
module tb_reg_file_wb_decode;
  import rf_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid;
  logic [4:0]  iss_rd;
  logic        wb_en;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rd_en;
  logic [4:0]  ra_addr, rb_addr;
  logic [31:0] ra_data, rb_data;
  logic        rd_valid, hazard;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] m_regs [32];
  logic        m_sb   [32];
  logic [31:0] exp_ra, exp_rb;
  logic        exp_valid;

  reg_file_wb_decode dut (
    .clk(clk), .rst(rst), .iss_valid(iss_valid), .iss_rd(iss_rd),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .rd_en(rd_en),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .rd_valid(rd_valid), .hazard(hazard)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    for (int i = 0; i < 32; i++) begin
      m_regs[i] = '0;
      m_sb[i]   = 1'b0;
    end
    exp_ra = '0; exp_rb = '0; exp_valid = 1'b0;
  endtask

  // A port hazards when its register is reserved and not being written right now.
  function automatic logic exp_hazard();
    logic ha, hb;
    ha = (ra_addr != 0) && m_sb[ra_addr] && !(wb_en && wb_addr == ra_addr);
    hb = (rb_addr != 0) && m_sb[rb_addr] && !(wb_en && wb_addr == rb_addr);
    return ha || hb;
  endfunction

  task automatic idle();
    iss_valid = 0; iss_rd = 0; wb_en = 0; wb_addr = 0; wb_data = 0;
    rd_en = 0; ra_addr = 0; rb_addr = 0;
  endtask

  // Advance one clock edge, updating the model with the inputs seen at that edge.
  task automatic tick();
    logic [31:0] na, nb;
    na = (ra_addr == 0) ? 32'd0 : (wb_en && wb_addr == ra_addr) ? wb_data : m_regs[ra_addr];
    nb = (rb_addr == 0) ? 32'd0 : (wb_en && wb_addr == rb_addr) ? wb_data : m_regs[rb_addr];
    @(posedge clk);
    exp_valid = rd_en;
    if (rd_en) begin exp_ra = na; exp_rb = nb; end
    if (wb_en && wb_addr != 0) m_regs[wb_addr] = wb_data;
    if (wb_en) m_sb[wb_addr] = 1'b0;
    if (iss_valid && iss_rd != 0) m_sb[iss_rd] = 1'b1;
    #1;
  endtask

  function automatic logic [4:0] rand_addr();
    if ($urandom_range(0, 3) == 0) return 5'($urandom_range(0, 31));
    return 5'($urandom_range(0, 7));
  endfunction

  task automatic test_reset();
    idle();
    rst = 1'b1;
    #2;
    n_checks++; if (ra_data !== 32'd0) begin n_fail++; $display("FAIL reset_ra got=%h exp=0", ra_data); end
    n_checks++; if (rb_data !== 32'd0) begin n_fail++; $display("FAIL reset_rb got=%h exp=0", rb_data); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid got=%b exp=0", rd_valid); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL reset_hazard got=%b exp=0", hazard); end
    #10 rst = 1'b0;
    model_reset();
    #1;
  endtask

  task automatic test_write_read();
    idle(); wb_en = 1; wb_addr = 5; wb_data = 32'hDEADBEEF;
    tick();
    idle(); rd_en = 1; ra_addr = 5; rb_addr = 6;
    tick();
    n_checks++; if (ra_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_data got=%h exp=deadbeef", ra_data); end
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL wr_rd_valid got=%b exp=1", rd_valid); end
    idle();
    tick();
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL wr_rd_valid_drop got=%b exp=0", rd_valid); end
    n_checks++; if (ra_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL wr_rd_hold got=%h exp=deadbeef", ra_data); end
  endtask

  task automatic test_zero_reg();
    idle(); wb_en = 1; wb_addr = REG_ZERO; wb_data = 32'hFFFFFFFF;
    tick();
    idle(); rd_en = 1; ra_addr = REG_ZERO; rb_addr = REG_ZERO;
    tick();
    n_checks++; if (ra_data !== 32'd0) begin n_fail++; $display("FAIL zero_ra got=%h exp=0", ra_data); end
    n_checks++; if (rb_data !== 32'd0) begin n_fail++; $display("FAIL zero_rb got=%h exp=0", rb_data); end
    idle(); iss_valid = 1; iss_rd = REG_ZERO;
    tick();
    idle(); ra_addr = REG_ZERO; rb_addr = REG_ZERO;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL zero_hazard got=%b exp=0", hazard); end
  endtask

  task automatic test_bypass();
    idle(); iss_valid = 1; iss_rd = REG_LINK;
    tick();
    idle(); wb_en = 1; wb_addr = REG_LINK; wb_data = 32'h1234;
    rd_en = 1; ra_addr = REG_LINK; rb_addr = REG_LINK;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL bypass_hazard got=%b exp=0", hazard); end
    tick();
    n_checks++; if (ra_data !== 32'h1234) begin n_fail++; $display("FAIL bypass_ra got=%h exp=1234", ra_data); end
    n_checks++; if (rb_data !== 32'h1234) begin n_fail++; $display("FAIL bypass_rb got=%h exp=1234", rb_data); end
    n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid got=%b exp=1", rd_valid); end
  endtask

  task automatic test_scoreboard();
    idle(); iss_valid = 1; iss_rd = 7;
    tick();
    idle(); ra_addr = 7;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL sb_set_hazard got=%b exp=1", hazard); end
    wb_en = 1; wb_addr = 7; wb_data = 32'hCAFE0007;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_wb_hazard got=%b exp=0", hazard); end
    tick();
    idle(); ra_addr = 7; rb_addr = 7;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL sb_cleared got=%b exp=0", hazard); end
  endtask

  task automatic test_collision();
    idle(); iss_valid = 1; iss_rd = 9; wb_en = 1; wb_addr = 9; wb_data = 32'h99;
    tick();
    idle(); ra_addr = 9;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL collision_hazard got=%b exp=1", hazard); end
    idle(); wb_en = 1; wb_addr = 9; wb_data = 32'h100;
    tick();
    idle(); rb_addr = 9;
    #1;
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL collision_release got=%b exp=0", hazard); end
  endtask

  task automatic test_random();
    logic eh;
    for (int n = 0; n < 400; n++) begin
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = rand_addr();
      wb_en     = ($urandom_range(0, 1) == 0);
      wb_addr   = rand_addr();
      wb_data   = $urandom;
      rd_en     = ($urandom_range(0, 2) != 0);
      ra_addr   = rand_addr();
      rb_addr   = rand_addr();
      #1;
      eh = exp_hazard();
      n_checks++; if (hazard !== eh) begin n_fail++; $display("FAIL rand_hazard it=%0d got=%b exp=%b", n, hazard, eh); end
      tick();
      n_checks++; if (rd_valid !== exp_valid) begin n_fail++; $display("FAIL rand_valid it=%0d got=%b exp=%b", n, rd_valid, exp_valid); end
      n_checks++; if (ra_data !== exp_ra) begin n_fail++; $display("FAIL rand_ra it=%0d got=%h exp=%h", n, ra_data, exp_ra); end
      n_checks++; if (rb_data !== exp_rb) begin n_fail++; $display("FAIL rand_rb it=%0d got=%h exp=%h", n, rb_data, exp_rb); end
    end
    idle();
  endtask

  task automatic test_mid_reset();
    idle(); wb_en = 1; wb_addr = 3; wb_data = 32'hA5A5A5A5;
    tick();
    idle(); iss_valid = 1; iss_rd = 3; rd_en = 1; ra_addr = 3; rb_addr = 3;
    tick();
    n_checks++; if (ra_data !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL pre_rst_ra got=%h exp=a5a5a5a5", ra_data); end
    idle(); ra_addr = 3;
    #1;
    n_checks++; if (hazard !== 1'b1) begin n_fail++; $display("FAIL pre_rst_hazard got=%b exp=1", hazard); end
    #1 rst = 1'b1;
    #1;
    n_checks++; if (ra_data !== 32'd0) begin n_fail++; $display("FAIL mid_rst_ra got=%h exp=0", ra_data); end
    n_checks++; if (rb_data !== 32'd0) begin n_fail++; $display("FAIL mid_rst_rb got=%h exp=0", rb_data); end
    n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got=%b exp=0", rd_valid); end
    n_checks++; if (hazard !== 1'b0) begin n_fail++; $display("FAIL mid_rst_hazard got=%b exp=0", hazard); end
    model_reset();
    @(posedge clk); #3 rst = 1'b0;
    for (int a = 0; a < 32; a += 2) begin
      idle(); rd_en = 1; ra_addr = 5'(a); rb_addr = 5'(a + 1);
      tick();
      n_checks++; if (ra_data !== 32'd0) begin n_fail++; $display("FAIL post_rst_ra addr=%0d got=%h exp=0", a, ra_data); end
      n_checks++; if (rb_data !== 32'd0) begin n_fail++; $display("FAIL post_rst_rb addr=%0d got=%h exp=0", a + 1, rb_data); end
    end
    idle();
  endtask

  initial begin
    model_reset();
    test_reset();
    test_write_read();
    test_zero_reg();
    test_bypass();
    test_scoreboard();
    test_collision();
    test_random();
    test_mid_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
